// File: rtl/zfp_inv_cast.sv
// zfp_inv_cast: rebuilds IEEE-754 double fields from block-exponent fixed-point values.
// Define ZFP_INV_CAST_RNE_EN for round-to-nearest-even (adds one pipeline stage).
module zfp_inv_cast #(
  parameter int BLOCK_LEN = 4,
  parameter int IW        = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   s_ex_data,
  input  logic          s_ex_valid,
  output logic          s_ex_ready,
  input  logic [IW-1:0] s_int_data,
  input  logic          s_int_valid,
  output logic          s_int_ready,
  output logic [51:0]   m_fp_data_frac,
  output logic [10:0]   m_fp_data_expo,
  output logic          m_fp_data_sign,
  output logic          m_fp_valid,
  input  logic          m_fp_ready
);

  localparam int CW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLOCK_LEN - 1);

  typedef enum logic {WAIT_EX, STREAM} state_e;

  state_e        state_q;
  logic [CW-1:0] count_q;
  logic [10:0]   exp_q;

  logic adv, intFire, blkEnd, exFire, outValid;

  logic          st1Valid_q, st1Valid_d;
  logic          st1Sign_q, st1Sign_d;
  logic [63:0]   st1Mag_q, st1Mag_d;
  logic [10:0]   st1Exp_q, st1Exp_d;
  logic          st2Valid_q, st2Valid_d;

  logic [5:0]    lz;
  logic [12:0]   eSum;

`ifdef ZFP_INV_CAST_RNE_EN
  logic          st2Sign_q, st2Sign_d;
  logic          st2Zero_q, st2Zero_d;
  logic [12:0]   st2Exp_q, st2Exp_d;
  logic [62:0]   st2Norm_q, st2Norm_d;
  logic          st3Valid_q, st3Valid_d;
  logic [63:0]   st3Fp_q, st3Fp_d;
  logic [62:0]   norm;
  logic          roundUp;
`else
  logic [63:0]   st2Fp_q, st2Fp_d;
  logic [51:0]   fracTrunc;
`endif

  function automatic logic [5:0] lzc64(input logic [63:0] v);
    lzc64 = 6'd0;
    for (int i = 0; i < 64; i++)
      if (v[i]) lzc64 = 6'(63 - i);
  endfunction

  // Rounding carry bumps the exponent before the flush/saturate range checks.
  function automatic logic [63:0] packFp(input logic sign, input logic isZero,
                                         input logic [12:0] eIn, input logic [51:0] fracIn,
                                         input logic rnd);
    logic [52:0] fracRnd;
    logic [12:0] eRnd;
    fracRnd = {1'b0, fracIn} + {52'd0, rnd};
    eRnd    = eIn + {12'd0, fracRnd[52]};
    if (isZero)
      packFp = 64'd0;
    else if (eRnd[12] || eRnd == 13'd0)
      packFp = {sign, 63'd0};
    else if (eRnd >= 13'd2047)
      packFp = {sign, 11'h7ff, 52'd0};
    else
      packFp = {sign, eRnd[10:0], fracRnd[51:0]};
  endfunction

  assign adv         = !outValid || m_fp_ready;
  assign s_int_ready = reset && (state_q == STREAM) && adv;
  assign intFire     = s_int_valid && s_int_ready;
  assign blkEnd      = intFire && (count_q == LAST);
  assign s_ex_ready  = reset && ((state_q == WAIT_EX) || blkEnd);
  assign exFire      = s_ex_valid && s_ex_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= WAIT_EX;
      count_q <= '0;
      exp_q   <= '0;
    end else begin
      case (state_q)
        WAIT_EX: begin
          if (exFire) begin
            exp_q   <= s_ex_data;
            count_q <= '0;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (intFire) begin
            if (blkEnd) begin
              count_q <= '0;
              if (exFire) exp_q <= s_ex_data;
              else        state_q <= WAIT_EX;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        default: state_q <= WAIT_EX;
      endcase
    end
  end

  assign lz   = lzc64(st1Mag_q);
  assign eSum = {2'b00, st1Exp_q} + 13'd1 - {7'd0, lz};

`ifdef ZFP_INV_CAST_RNE_EN
  assign norm    = 63'(st1Mag_q << lz);
  assign roundUp = st2Norm_q[10] && (st2Norm_q[11] || (|st2Norm_q[9:0]));
  assign outValid = st3Valid_q;
  assign {m_fp_data_sign, m_fp_data_expo, m_fp_data_frac} = st3Fp_q;
`else
  assign fracTrunc = 52'((st1Mag_q << lz) >> 11);
  assign outValid  = st2Valid_q;
  assign {m_fp_data_sign, m_fp_data_expo, m_fp_data_frac} = st2Fp_q;
`endif
  assign m_fp_valid = outValid;

  // Stall-all pipe: every stage advances together only when the output can move.
  always_comb begin
    st1Valid_d = st1Valid_q;
    st1Sign_d  = st1Sign_q;
    st1Mag_d   = st1Mag_q;
    st1Exp_d   = st1Exp_q;
    st2Valid_d = st2Valid_q;
`ifdef ZFP_INV_CAST_RNE_EN
    st2Sign_d  = st2Sign_q;
    st2Zero_d  = st2Zero_q;
    st2Exp_d   = st2Exp_q;
    st2Norm_d  = st2Norm_q;
    st3Valid_d = st3Valid_q;
    st3Fp_d    = st3Fp_q;
`else
    st2Fp_d    = st2Fp_q;
`endif
    if (adv) begin
      st1Valid_d = intFire;
      st1Sign_d  = s_int_data[IW-1];
      st1Mag_d   = s_int_data[IW-1] ? (~s_int_data + 64'd1) : s_int_data;
      st1Exp_d   = exp_q;
      st2Valid_d = st1Valid_q;
`ifdef ZFP_INV_CAST_RNE_EN
      st2Sign_d  = st1Sign_q;
      st2Zero_d  = (st1Mag_q == 64'd0);
      st2Exp_d   = eSum;
      st2Norm_d  = norm;
      st3Valid_d = st2Valid_q;
      st3Fp_d    = packFp(st2Sign_q, st2Zero_q, st2Exp_q, st2Norm_q[62:11], roundUp);
`else
      st2Fp_d    = packFp(st1Sign_q, st1Mag_q == 64'd0, eSum, fracTrunc, 1'b0);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st1Valid_q <= 1'b0;
      st1Sign_q  <= 1'b0;
      st1Mag_q   <= '0;
      st1Exp_q   <= '0;
      st2Valid_q <= 1'b0;
`ifdef ZFP_INV_CAST_RNE_EN
      st2Sign_q  <= 1'b0;
      st2Zero_q  <= 1'b0;
      st2Exp_q   <= '0;
      st2Norm_q  <= '0;
      st3Valid_q <= 1'b0;
      st3Fp_q    <= '0;
`else
      st2Fp_q    <= '0;
`endif
    end else begin
      st1Valid_q <= st1Valid_d;
      st1Sign_q  <= st1Sign_d;
      st1Mag_q   <= st1Mag_d;
      st1Exp_q   <= st1Exp_d;
      st2Valid_q <= st2Valid_d;
`ifdef ZFP_INV_CAST_RNE_EN
      st2Sign_q  <= st2Sign_d;
      st2Zero_q  <= st2Zero_d;
      st2Exp_q   <= st2Exp_d;
      st2Norm_q  <= st2Norm_d;
      st3Valid_q <= st3Valid_d;
      st3Fp_q    <= st3Fp_d;
`else
      st2Fp_q    <= st2Fp_d;
`endif
    end
  end

endmodule

// File: tb/tb_zfp_inv_cast.sv
// tb_zfp_inv_cast: scoreboard bench for zfp_inv_cast; exact-integer double model,
// directed boundary cases, back-to-back blocks, output stall and mid-block reset.
module tb_zfp_inv_cast;
  localparam int BL = 4;
`ifdef ZFP_INV_CAST_RNE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] s_ex_data = '0;
  logic        s_ex_valid = 1'b0;
  logic        s_ex_ready;
  logic [63:0] s_int_data = '0;
  logic        s_int_valid = 1'b0;
  logic        s_int_ready;
  logic [51:0] m_fp_data_frac;
  logic [10:0] m_fp_data_expo;
  logic        m_fp_data_sign;
  logic        m_fp_valid;
  logic        m_fp_ready;
  logic [63:0] dutFp;

  zfp_inv_cast #(.BLOCK_LEN(BL), .IW(64)) dut (
    .clk(clk), .reset(reset),
    .s_ex_data(s_ex_data), .s_ex_valid(s_ex_valid), .s_ex_ready(s_ex_ready),
    .s_int_data(s_int_data), .s_int_valid(s_int_valid), .s_int_ready(s_int_ready),
    .m_fp_data_frac(m_fp_data_frac), .m_fp_data_expo(m_fp_data_expo),
    .m_fp_data_sign(m_fp_data_sign), .m_fp_valid(m_fp_valid), .m_fp_ready(m_fp_ready)
  );

  always #5 clk = ~clk;
  assign dutFp = {m_fp_data_sign, m_fp_data_expo, m_fp_data_frac};

  typedef struct { logic [63:0] fp; int cyc; } exp_t;

  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          readyPct = 100;
  bit          exactLat = 1'b0;
  int          blkCnt = 0;
  int          stallCycles = 0;
  bit          stallHeld = 1'b0;
  logic [63:0] heldFp;
  logic [10:0] eQ[$];
  exp_t        expQ[$];
  logic [10:0] exArr[$];
  logic [63:0] intArr[$];
  int          exFireCyc[$];
  int          intFireCyc[$];
  int          outCyc[$];
  logic [63:0] outLog[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  // Value = int * 2^(E-1085); with the leading one at bit p the biased exponent is E+p-62.
  function automatic logic [63:0] modelFp(input logic [10:0] e, input logic [63:0] v);
    logic        s;
    logic [63:0] m;
    logic [51:0] frac;
    int          p, ex;
`ifdef ZFP_INV_CAST_RNE_EN
    logic [63:0] rem, half;
`endif
    s = v[63];
    m = s ? (64'd0 - v) : v;
    if (m == 64'd0) return 64'd0;
    p = 63;
    while (!m[p]) p--;
    ex = int'(e) + p - 62;
    if (p >= 52) frac = 52'(m >> (p - 52));
    else         frac = 52'(m << (52 - p));
`ifdef ZFP_INV_CAST_RNE_EN
    if (p > 52) begin
      rem  = m & ((64'd1 << (p - 52)) - 64'd1);
      half = 64'd1 << (p - 53);
      if (rem > half || (rem == half && frac[0])) begin
        if (frac == '1) ex++;
        frac = frac + 52'd1;
      end
    end
`endif
    if (ex <= 0) return {s, 63'd0};
    if (ex >= 2047) return {s, 11'h7ff, 52'd0};
    return {s, 11'(ex), frac};
  endfunction

  function automatic logic [63:0] randInt();
    logic [63:0] v;
    case ($urandom_range(0, 9))
      0: v = 64'd0;
      1: v = 64'h8000_0000_0000_0000;
      default: begin
        v = {$urandom, $urandom} >> $urandom_range(0, 63);
        if ($urandom_range(0, 1) == 1) v = 64'd0 - v;
      end
    endcase
    return v;
  endfunction

  function automatic logic [10:0] randExp();
    case ($urandom_range(0, 7))
      0: return 11'd0;
      1: return 11'd1;
      2: return 11'd2046;
      3: return 11'd2047;
      default: return 11'($urandom_range(960, 1090));
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    m_fp_ready = ($urandom_range(0, 99) < readyPct);
  end

  // Single compare process: tracks accepted exponents/values and scores every output handshake.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      eQ.delete();
      expQ.delete();
      blkCnt = 0;
      stallHeld = 1'b0;
      checkOutput("ready during reset", {62'd0, s_ex_ready, s_int_ready}, 64'd0);
    end else begin
      if (stallHeld) begin
        checkOutput("valid held in stall", {63'd0, m_fp_valid}, 64'd1);
        checkOutput("data held in stall", dutFp, heldFp);
      end
      if (s_int_valid && s_int_ready) begin
        checkOutput("exponent present at int accept", {63'd0, eQ.size() > 0}, 64'd1);
        if (eQ.size() > 0) begin
          expQ.push_back('{modelFp(eQ[0], s_int_data), cyc});
          blkCnt++;
          if (blkCnt == BL) begin
            void'(eQ.pop_front());
            blkCnt = 0;
          end
        end
        intFireCyc.push_back(cyc);
      end
      if (s_ex_valid && s_ex_ready) begin
        eQ.push_back(s_ex_data);
        exFireCyc.push_back(cyc);
      end
      if (m_fp_valid && m_fp_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected output: got 0x%h, expected no output", dutFp);
        end else begin
          exp_t it;
          it = expQ.pop_front();
          checkOutput("fp fields", dutFp, it.fp);
          if (exactLat) checkOutput("latency", 64'(cyc - it.cyc), 64'(LAT));
        end
        outCyc.push_back(cyc);
        outLog.push_back(dutFp);
      end
      if (m_fp_valid && !m_fp_ready) begin
        checkOutput("int ready low while stalled", {63'd0, s_int_ready}, 64'd0);
        stallHeld = 1'b1;
        heldFp = dutFp;
        stallCycles++;
      end else begin
        stallHeld = 1'b0;
      end
    end
  end

  task automatic waitFire(input bit isEx, input string name);
    bit fired;
    fired = 1'b0;
    for (int n = 0; n < 2000 && !fired; n++) begin
      @(negedge clk);
      fired = isEx ? (s_ex_valid && s_ex_ready) : (s_int_valid && s_int_ready);
    end
    if (!fired) begin
      checks++;
      $display("[TB] FAIL %s handshake: got none, expected one within 2000 cycles", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic driveEx(input int gapPct);
    foreach (exArr[i]) begin
      if ($urandom_range(0, 99) < gapPct) begin
        s_ex_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      s_ex_valid = 1'b1;
      s_ex_data  = exArr[i];
      waitFire(1'b1, "ex");
    end
    s_ex_valid = 1'b0;
  endtask

  task automatic driveInt(input int gapPct);
    foreach (intArr[i]) begin
      if ($urandom_range(0, 99) < gapPct) begin
        s_int_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      s_int_valid = 1'b1;
      s_int_data  = intArr[i];
      waitFire(1'b0, "int");
    end
    s_int_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int gapPct);
    fork
      driveEx(gapPct);
      driveInt(gapPct);
    join
    readyPct = 100;
    for (int n = 0; n < 100 && expQ.size() != 0; n++) @(negedge clk);
    if (expQ.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain: got %0d pending outputs, expected 0", expQ.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    exFireCyc.delete();
    intFireCyc.delete();
    outCyc.delete();
    outLog.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global timeout: got no finish, expected end of test");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checkOutput("model 1.0", modelFp(11'd1023, 64'h4000_0000_0000_0000), 64'h3FF0_0000_0000_0000);
    checkOutput("model -1.5", modelFp(11'd1023, 64'hA000_0000_0000_0000), 64'hBFF8_0000_0000_0000);
    checkOutput("model zero", modelFp(11'd1023, 64'd0), 64'd0);
    checkOutput("model saturate", modelFp(11'd2046, 64'h8000_0000_0000_0000), 64'hFFF0_0000_0000_0000);
    checkOutput("model flush", modelFp(11'd1, 64'd1), 64'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset valid", {63'd0, m_fp_valid}, 64'd0);
    checkOutput("reset fields", dutFp, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed conversions");
    clearLogs();
    exactLat = 1'b1;
    exArr  = '{11'd1023, 11'd2046, 11'd1};
    intArr = '{64'h4000_0000_0000_0000, 64'hA000_0000_0000_0000, 64'd0, 64'd1,
               64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'd1, 64'd0,
               64'd1, 64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000};
    applyStimulus(0);
    checkOutput("dir out count", 64'(outLog.size()), 64'd12);
    checkOutput("dir 1.0", outLog[0], 64'h3FF0_0000_0000_0000);
    checkOutput("dir -1.5", outLog[1], 64'hBFF8_0000_0000_0000);
    checkOutput("dir zero", outLog[2], 64'd0);
    checkOutput("dir saturate", outLog[4], 64'hFFF0_0000_0000_0000);
    checkOutput("dir flush", outLog[8], 64'd0);

    $display("[TB] back-to-back blocks");
    clearLogs();
    exArr  = '{11'd1023, 11'd1024};
    intArr.delete();
    for (int i = 0; i < 2 * BL; i++) intArr.push_back(64'h4000_0000_0000_0000);
    applyStimulus(0);
    exactLat = 1'b0;
    checkOutput("b2b ex accepts", 64'(exFireCyc.size()), 64'd2);
    checkOutput("b2b ex with 4th int",
                (exFireCyc.size() > 1 && intFireCyc.size() > 3) ? 64'(exFireCyc[1] - intFireCyc[3]) : 64'hDEAD,
                64'd0);
    checkOutput("b2b out count", 64'(outCyc.size()), 64'd8);
    checkOutput("b2b no bubble", (outCyc.size() == 8) ? 64'(outCyc[7] - outCyc[0]) : 64'hDEAD, 64'd7);
    checkOutput("b2b first", outLog[0], 64'h3FF0_0000_0000_0000);
    checkOutput("b2b last", outLog[7], 64'h4000_0000_0000_0000);

    $display("[TB] output stall");
    clearLogs();
    stallCycles = 0;
    exArr  = '{11'd1000, 11'd1010, 11'd1020};
    intArr.delete();
    for (int i = 0; i < 3 * BL; i++) intArr.push_back(64'(i + 1) << 50);
    fork
      applyStimulus(0);
      begin
        repeat (5) @(posedge clk);
        readyPct = 0;
        repeat (5) @(posedge clk);
        readyPct = 100;
      end
    join
    checkOutput("stall seen", {63'd0, stallCycles >= 4}, 64'd1);
    checkOutput("stall out count", 64'(outLog.size()), 64'(3 * BL));

    $display("[TB] reset mid-block");
    s_ex_valid = 1'b1;
    s_ex_data  = 11'd1023;
    waitFire(1'b1, "rst ex");
    s_ex_valid  = 1'b0;
    s_int_valid = 1'b1;
    s_int_data  = 64'h4000_0000_0000_0000;
    waitFire(1'b0, "rst int0");
    s_int_data  = 64'h2000_0000_0000_0000;
    waitFire(1'b0, "rst int1");
    s_int_data  = 64'h1000_0000_0000_0000;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("valid after reset", {63'd0, m_fp_valid}, 64'd0);
    checkOutput("int ready after reset", {63'd0, s_int_ready}, 64'd0);
    checkOutput("ex ready after reset", {63'd0, s_ex_ready}, 64'd1);
    repeat (3) begin
      @(negedge clk);
      checkOutput("int ready without exp", {63'd0, s_int_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    s_int_valid = 1'b0;
    clearLogs();
    exArr  = '{11'd1030};
    intArr = '{64'd3, 64'h7FFF_FFFF_FFFF_FFFF, 64'hF000_0000_0000_0001, 64'd1 << 40};
    applyStimulus(0);
    checkOutput("post reset out count", 64'(outLog.size()), 64'd4);

    $display("[TB] randomized stream");
    exArr.delete();
    intArr.delete();
    for (int b = 0; b < 30; b++) begin
      exArr.push_back(randExp());
      for (int i = 0; i < BL; i++) intArr.push_back(randInt());
    end
    readyPct = 70;
    applyStimulus(30);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/zfp_inv_cast.md
Name: zfp_inv_cast

Overview:
Decode-side counterpart of the block-exponent encoder front end. Takes a stream of per-block biased exponents (emax) and a stream of signed 64-bit fixed-point block values. Rebuilds IEEE-754 double fields (frac/expo/sign) for every value. Sits after the integer decode stage and drives the FP output channel of the decompressor.

Parameters:
BLOCK_LEN, 4, values per block sharing one exponent (>=1)
IW, 64, fixed-point integer width (fixed at 64 for double)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous active-low reset
s_ex_data  in  11  biased block exponent E
s_ex_valid  in  1  exponent valid
s_ex_ready  out  1  exponent accepted when valid&&ready
s_int_data  in  64  two's-complement value; real value = int * 2^(E-1023-62)
s_int_valid  in  1  value valid
s_int_ready  out  1  value accepted when valid&&ready
m_fp_data_frac  out  52  fraction
m_fp_data_expo  out  11  biased exponent
m_fp_data_sign  out  1  sign
m_fp_valid  out  1  output valid
m_fp_ready  in  1  downstream ready

Behaviour:
- One clock (clk); reset synchronous, active-low (reset==0 resets on the clk edge).
- Reset: state=WAIT_EX, count=0, held E=0, both pipe stages empty. m_fp_valid=0, m_fp_data_frac/expo/sign=0. s_ex_ready=0 and s_int_ready=0 while reset==0. Reset mid-block discards held E, partial count and in-flight values.
- FSM WAIT_EX: s_ex_ready=1, s_int_ready=0. On ex handshake, latch E, count=0, go to STREAM.
- FSM STREAM: s_int_ready=adv (pipe advance, below). Each int handshake increments count.
  - If count==BLOCK_LEN-1 at an int handshake, the block ends: count=0.
  - Block end with s_ex_valid=1 in the same cycle: s_ex_ready=1 that cycle, the new E is latched, state stays STREAM (back-to-back blocks, no bubble).
  - Block end without s_ex_valid: go to WAIT_EX.
  - s_ex_ready=0 in STREAM at all other times.
- Pipe: 2 register stages, stall-all. adv = !st2_valid || m_fp_ready. Both stages load only when adv=1.
  - Stage 1 registers sign=int[63], mag=|int| as unsigned 64 (int=-2^63 gives mag=2^63), and the E in force for that value.
  - Stage 2 registers the fp fields; m_fp_* are stage 2 outputs.
  - Latency: accept to m_fp_valid = 2 cycles. Throughput 1/cycle when m_fp_ready=1.
  - m_fp_* hold stable while m_fp_valid=1 and m_fp_ready=0.
- Conversion, in stage 2:
  - lz = leading-zero count of mag (0..63).
  - e = E + 1 - lz, computed as 13-bit signed.
  - frac = the 52 bits directly below the leading one, left-aligned; missing low bits zero; truncate (round toward zero).
  - mag==0 gives expo=0, frac=0, sign=0.
  - e<=0 flushes to zero: expo=0, frac=0, sign kept (no subnormals).
  - e>=2047 saturates to infinity: expo=2047, frac=0, sign kept.
  - Otherwise expo=e[10:0].
- E=0 with nonzero ints follows the same rules (normally yields flush-to-zero).

Optional Feature:
ZFP_INV_CAST_RNE_EN:
- Defined: round-to-nearest-even on the discarded bits below frac (guard/sticky).
  - Fraction overflow on rounding gives frac=0 and e+1, with the overflow check applied after rounding.
  - Adds one pipeline stage: latency 3.
- Undefined: truncation, latency 2.

Test Plan:
- E=1023, int=2^62 (0x4000000000000000) -> expo=1023, frac=0, sign=0 (1.0) on cycle 2 after accept.
- E=1023, int=-(3*2^61) -> sign=1, expo=1023, frac=0x8000000000000 (-1.5). Same E, int=0 -> expo=0, frac=0, sign=0.
- Boundaries:
  - E=2046, int=-2^63 -> sign=1, expo=2047, frac=0 (saturate).
  - E=1, int=1 -> e=-61, expo=0, frac=0 (flush).
- BLOCK_LEN=4, exps {1023,1024} with s_ex_valid held high, 8 ints each 2^62:
  - outputs expo 1023 x4 then 1024 x4;
  - second exponent accepted in the same cycle as the 4th int;
  - no bubble on m_fp_valid.
- Hold m_fp_ready=0 for 5 cycles mid-stream:
  - m_fp_* stable;
  - s_int_ready=0 once both stages are full;
  - no value lost or duplicated after release (count-ordered check).
- Pull reset=0 for one cycle after 2 of 4 ints of a block:
  - m_fp_valid=0 next cycle, state WAIT_EX, s_int_ready=0;
  - a fresh exponent is required before any int is accepted.
